// File: rtl/wrr_pkt_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package wrr_pkt_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } wrr_state_e;

  // One-hot to binary; ORing indices is exact for one-hot input and 0 for all-zero.
  function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_pkt_arbiter_pick.sv
// Combinational rotating-priority first-one finder: scans req from ptr upward, wrapping.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  assign any = |req;

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    int cand;
    cand     = 0;
    pick_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N;
      if (req[cand]) pick_idx = IDX_W'(cand);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_pick
    assign pick[gi] = any && (int'(pick_idx) == gi);
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin packet arbiter: owner holds the channel for up to weight packets.
module wrr_pkt_arbiter
  import wrr_pkt_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic                         allow_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         out_valid_o,
  output logic                         out_last_o,
  input  logic                         out_ready_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [IDX_W-1:0]             gnt_idx_o
);

  wrr_state_e          state_q, state_next;
  logic [NUM_REQ-1:0]  gnt_q, gnt_next;
  logic [IDX_W-1:0]    ptr_q, ptr_next;
  logic [WEIGHT_W-1:0] credit_q, credit_next;
  logic                pkt_open_q, pkt_open_next;

  logic [NUM_REQ-1:0]  pick;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [IDX_W-1:0]    gnt_idx;
  logic [WEIGHT_W-1:0] win_weight;
  logic                busy, own_valid, own_last, xfer, pkt_end, early_rel, rel_now;

  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .req      (req_valid_i),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  assign gnt_idx    = IDX_W'(onehot_to_idx(32'(gnt_q)));
  assign win_weight = weight_i[pick_idx*WEIGHT_W +: WEIGHT_W];

  assign busy        = (state_q == BUSY);
  assign own_valid   = |(req_valid_i & gnt_q);
  assign own_last    = |(req_last_i & gnt_q);
  assign out_valid_o = busy & own_valid;
  assign out_last_o  = busy & own_last;
  assign req_ready_o = busy ? (gnt_q & {NUM_REQ{out_ready_i}}) : '0;

  assign xfer      = out_valid_o & out_ready_i;
  assign pkt_end   = xfer & out_last_o;
  // Owner idle between packets gives up the channel rather than starving others.
  assign early_rel = busy & ~pkt_open_q & ~own_valid;
  assign rel_now   = early_rel | (pkt_end & (credit_q == WEIGHT_W'(1)));

  always_comb begin
    state_next    = state_q;
    gnt_next      = gnt_q;
    ptr_next      = ptr_q;
    credit_next   = credit_q;
    pkt_open_next = pkt_open_q;
    case (state_q)
      IDLE: begin
        if (allow_i && pick_any) begin
          state_next  = BUSY;
          gnt_next    = pick;
          credit_next = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
        end
      end
      BUSY: begin
        if (xfer) pkt_open_next = ~out_last_o;
        if (rel_now) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
        end else if (pkt_end) begin
          credit_next = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      credit_q   <= '0;
      pkt_open_q <= 1'b0;
    end else begin
      state_q    <= state_next;
      gnt_q      <= gnt_next;
      ptr_q      <= ptr_next;
      credit_q   <= credit_next;
      pkt_open_q <= pkt_open_next;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx;

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Directed-vector bench for wrr_pkt_arbiter with hand-computed expectations.
module tb_wrr_pkt_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        allow_i;
  logic [15:0] weight_i;
  logic [3:0]  req_valid_i, req_last_i, req_ready_o, gnt_o;
  logic        out_valid_o, out_last_o, out_ready_i;
  logic [1:0]  gnt_idx_o;

  int n_vec = 0;
  int n_err = 0;

  wrr_pkt_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .allow_i     (allow_i),
    .weight_i    (weight_i),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    arst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 arst_ni = 1'b1;
  endtask

  task automatic test_reset();
    allow_i = 1; weight_i = 16'h1111; req_valid_i = 4'b1111; req_last_i = 4'b1111;
    out_ready_i = 0; arst_ni = 0;
    #1;
    n_vec++;
    if (gnt_o !== 4'b0000 || gnt_idx_o !== 2'd0) begin
      n_err++; $display("FAIL reset_gnt: got %b/%0d expected 0000/0", gnt_o, gnt_idx_o);
    end
    n_vec++;
    if (out_valid_o !== 1'b0 || out_last_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      n_err++; $display("FAIL reset_outs: got v=%b l=%b rdy=%b expected 0 0 0000",
                        out_valid_o, out_last_o, req_ready_o);
    end
    apply_reset();
    tick();
    n_vec++;
    if (gnt_o !== 4'b0001 || gnt_idx_o !== 2'd0) begin
      n_err++; $display("FAIL reset_first_gnt: got %b/%0d expected 0001/0", gnt_o, gnt_idx_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_wrr_order();
    logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                4'b0100, 4'b0000, 4'b1000, 4'b0000};
    allow_i = 1; weight_i = {4'd1, 4'd1, 4'd2, 4'd1};
    req_valid_i = 4'b1111; req_last_i = 4'b1111; out_ready_i = 1;
    apply_reset();
    for (int k = 0; k < 18; k++) begin
      tick();
      n_vec++;
      if (gnt_o !== exp_seq[k % 9]) begin
        n_err++; $display("FAIL wrr_order[%0d]: got %b expected %b", k, gnt_o, exp_seq[k % 9]);
      end
    end
    $display("test_wrr_order done");
  endtask

  task automatic test_wrr_ratio();
    int cnt [4] = '{0, 0, 0, 0};
    int w [4] = '{1, 2, 1, 1};
    int total = 0;
    int exp_cnt;
    allow_i = 1; weight_i = {4'd1, 4'd1, 4'd2, 4'd1};
    req_valid_i = 4'b1111; req_last_i = 4'b1111; out_ready_i = 1;
    apply_reset();
    for (int cyc = 0; cyc < 5000 && total < 1000; cyc++) begin
      tick();
      if (out_valid_o && out_ready_i && out_last_o) begin
        cnt[gnt_idx_o]++;
        total++;
      end
    end
    n_vec++;
    if (total !== 1000) begin
      n_err++; $display("FAIL ratio_timeout: got %0d grants expected 1000", total);
    end
    for (int i = 0; i < 4; i++) begin
      exp_cnt = 1000 * w[i] / 5;
      n_vec++;
      if (cnt[i] > exp_cnt + 1 || cnt[i] < exp_cnt - 1) begin
        n_err++; $display("FAIL ratio_req%0d: got %0d expected %0d +-1", i, cnt[i], exp_cnt);
      end
    end
    $display("test_wrr_ratio counts %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
  endtask

  task automatic test_long_packet();
    int b = 0;
    int n = 0;
    logic rdy;
    allow_i = 1; weight_i = 16'h1111;
    req_valid_i = 4'b0100; req_last_i = 4'b0000; out_ready_i = 0;
    apply_reset();
    tick();
    while (b < 4 && n < 20) begin
      rdy = (n % 2 == 0);
      out_ready_i = rdy;
      req_last_i = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      n_vec++;
      if (gnt_o !== 4'b0100 || req_ready_o !== {1'b0, rdy, 2'b00}) begin
        n_err++; $display("FAIL long_pkt[%0d]: got gnt=%b rdy=%b expected 0100 %b",
                          n, gnt_o, req_ready_o, {1'b0, rdy, 2'b00});
      end
      n_vec++;
      if (out_last_o !== (b == 3)) begin
        n_err++; $display("FAIL long_pkt_last[%0d]: got %b expected %b", n, out_last_o, (b == 3));
      end
      tick();
      if (rdy) b++;
      n++;
    end
    req_valid_i = 4'b0000;
    n_vec++;
    if (n !== 7) begin
      n_err++; $display("FAIL long_pkt_cycles: got %0d expected 7", n);
    end
    n_vec++;
    if (gnt_o !== 4'b0000) begin
      n_err++; $display("FAIL long_pkt_release: got %b expected 0000", gnt_o);
    end
    $display("test_long_packet done");
  endtask

  task automatic test_early_release();
    allow_i = 1; weight_i = {4'd1, 4'd1, 4'd3, 4'd1};
    req_valid_i = 4'b0010; req_last_i = 4'b0010; out_ready_i = 1;
    apply_reset();
    tick();
    n_vec++;
    if (gnt_o !== 4'b0010 || out_valid_o !== 1'b1 || req_ready_o !== 4'b0010) begin
      n_err++; $display("FAIL early_gnt: got gnt=%b v=%b rdy=%b expected 0010 1 0010",
                        gnt_o, out_valid_o, req_ready_o);
    end
    tick();
    req_valid_i = 4'b1101;
    #1;
    n_vec++;
    if (gnt_o !== 4'b0010 || out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL early_hold: got gnt=%b v=%b expected 0010 0", gnt_o, out_valid_o);
    end
    tick();
    n_vec++;
    if (gnt_o !== 4'b0000 || dut.ptr_q !== 2'd2) begin
      n_err++; $display("FAIL early_release: got gnt=%b ptr=%0d expected 0000 2", gnt_o, dut.ptr_q);
    end
    tick();
    n_vec++;
    if (gnt_o !== 4'b0100) begin
      n_err++; $display("FAIL early_next_gnt: got %b expected 0100", gnt_o);
    end
    $display("test_early_release done");
  endtask

  task automatic test_allow();
    allow_i = 0; weight_i = 16'h1111;
    req_valid_i = 4'b1111; req_last_i = 4'b0000; out_ready_i = 1;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (gnt_o !== 4'b0000) begin
        n_err++; $display("FAIL allow_block[%0d]: got %b expected 0000", i, gnt_o);
      end
    end
    allow_i = 1;
    tick();
    allow_i = 0;
    for (int i = 0; i < 3; i++) begin
      req_last_i = (i == 2) ? 4'b1111 : 4'b0000;
      #1;
      n_vec++;
      if (gnt_o !== 4'b0001 || out_valid_o !== 1'b1) begin
        n_err++; $display("FAIL allow_busy[%0d]: got gnt=%b v=%b expected 0001 1", i, gnt_o, out_valid_o);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (gnt_o !== 4'b0000) begin
        n_err++; $display("FAIL allow_after[%0d]: got %b expected 0000", i, gnt_o);
      end
      tick();
    end
    $display("test_allow done");
  endtask

  task automatic test_async_reset();
    allow_i = 1; weight_i = 16'h1111;
    req_valid_i = 4'b0100; req_last_i = 4'b0000; out_ready_i = 1;
    apply_reset();
    tick();
    tick();
    n_vec++;
    if (gnt_o !== 4'b0100) begin
      n_err++; $display("FAIL areset_pre: got %b expected 0100", gnt_o);
    end
    req_valid_i = 4'b1111; req_last_i = 4'b1111;
    #1 arst_ni = 0;
    #1;
    n_vec++;
    if (gnt_o !== 4'b0000 || gnt_idx_o !== 2'd0 || out_valid_o !== 1'b0 ||
        out_last_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      n_err++; $display("FAIL areset_outs: got gnt=%b idx=%0d v=%b l=%b rdy=%b expected all 0",
                        gnt_o, gnt_idx_o, out_valid_o, out_last_o, req_ready_o);
    end
    @(posedge clk_i);
    #1 arst_ni = 1;
    tick();
    n_vec++;
    if (gnt_o !== 4'b0001) begin
      n_err++; $display("FAIL areset_next_gnt: got %b expected 0001", gnt_o);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_wrr_order();
    test_wrr_ratio();
    test_long_packet();
    test_early_release();
    test_allow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
